// File: rtl/opb_err_cnt_bank.sv
`default_nettype none
// ============================================================================
// Module   : opb_err_cnt_bank
// Brief    : Bank of saturating error counters with snapshot/clear over OPB.
// Revision : 1.0 - initial release
// ============================================================================
module opb_err_cnt_bank #(
   parameter logic [31:0] C_BASEADDR   = 32'h01008B00,
   parameter logic [31:0] C_HIGHADDR   = 32'h01008BFF,
   parameter int          C_OPB_AWIDTH = 32,
   parameter int          C_OPB_DWIDTH = 32,
   parameter int          C_N_CH       = 8,
   parameter int          C_CNT_WIDTH  = 32
) (
   input  logic                      OPB_Clk,
   input  logic                      OPB_Rst_n,
   input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
   input  logic [0:3]                OPB_BE,
   input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
   input  logic                      OPB_RNW,
   input  logic                      OPB_select,
   input  logic                      OPB_seqAddr,
   input  logic [C_N_CH-1:0]         err_in,
   input  logic                      cnt_en,
   output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
   output logic                      Sl_xferAck,
   output logic                      Sl_errAck,
   output logic                      Sl_retry,
   output logic                      Sl_toutSup
);

   localparam int                     c_ww      = C_OPB_AWIDTH - 2;
   localparam logic [C_CNT_WIDTH-1:0] c_cnt_max = '1;

   logic [C_CNT_WIDTH-1:0]  r_cnt    [C_N_CH];
   logic [C_CNT_WIDTH-1:0]  r_shadow [C_N_CH];
   logic [C_N_CH-1:0]       r_sat;
   logic [C_N_CH-1:0]       r_clr_mask;
   logic                    r_ack;
   logic                    r_ack_d;
   logic [C_OPB_DWIDTH-1:0] r_dbus;

   logic [C_OPB_AWIDTH-1:0] w_addr;
   logic [C_OPB_AWIDTH-1:0] w_off;
   logic [c_ww-1:0]         w_word;
   logic [C_OPB_DWIDTH-1:0] w_wdata;
   logic [C_OPB_DWIDTH-1:0] w_rdata;
   logic [C_N_CH-1:0]       w_evt;
   logic                    w_hit;
   logic                    w_start;
   logic                    w_wr;
   logic                    w_snap;
   logic                    w_clear;
   logic                    w_mask_wr;
   logic                    w_unused;

   // Word-aligned address; the two byte-lane bits never affect decode.
   assign w_addr  = {OPB_ABus[0:C_OPB_AWIDTH-3], 2'b00};
   assign w_off   = w_addr - C_OPB_AWIDTH'(C_BASEADDR);
   assign w_word  = w_off[C_OPB_AWIDTH-1:2];
   assign w_wdata = OPB_DBus;
   assign w_evt   = err_in & {C_N_CH{cnt_en}};

   assign w_hit   = OPB_select
                    && (w_addr >= C_OPB_AWIDTH'(C_BASEADDR))
                    && (w_addr <= C_OPB_AWIDTH'(C_HIGHADDR));
   // Blocking the cycle after an ack keeps a lingering select from re-acking.
   assign w_start = w_hit && !r_ack && !r_ack_d;

   assign w_wr      = w_start && !OPB_RNW && (OPB_BE == 4'b1111);
   assign w_snap    = w_wr && (w_word == c_ww'(0)) && w_wdata[0];
   assign w_clear   = w_wr && (w_word == c_ww'(0)) && w_wdata[1];
   assign w_mask_wr = w_wr && (w_word == c_ww'(1));

   assign w_unused = &{1'b0, OPB_seqAddr, OPB_ABus[C_OPB_AWIDTH-2:C_OPB_AWIDTH-1],
                       w_off[1:0], w_wdata};

   always_comb begin
      w_rdata = '0;
      if (w_word == c_ww'(1)) begin
         w_rdata = C_OPB_DWIDTH'(r_clr_mask);
      end else if (w_word == c_ww'(2)) begin
         w_rdata = C_OPB_DWIDTH'(r_sat);
      end else if (w_word == c_ww'(3)) begin
         w_rdata = C_OPB_DWIDTH'({8'(C_CNT_WIDTH), 8'(C_N_CH)});
      end
      for (int i = 0; i < C_N_CH; i++) begin
         if (w_word == c_ww'(4 + i)) begin
            w_rdata = C_OPB_DWIDTH'(r_shadow[i]);
         end
      end
   end

   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) begin
         r_ack   <= 1'b0;
         r_ack_d <= 1'b0;
         r_dbus  <= '0;
      end else begin
         r_ack   <= w_start;
         r_ack_d <= r_ack;
         r_dbus  <= (w_start && OPB_RNW) ? w_rdata : '0;
      end
   end

   // Shadow load sees pre-update counts, so SNAP+CLEAR captures pre-clear values.
   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) begin
         r_sat      <= '0;
         r_clr_mask <= '0;
         for (int i = 0; i < C_N_CH; i++) begin
            r_cnt[i]    <= '0;
            r_shadow[i] <= '0;
         end
      end else begin
         if (w_mask_wr) begin
            r_clr_mask <= w_wdata[C_N_CH-1:0];
         end
         for (int i = 0; i < C_N_CH; i++) begin
            if (w_snap) begin
               r_shadow[i] <= r_cnt[i];
            end
            if (w_clear && r_clr_mask[i]) begin
               r_cnt[i] <= w_evt[i] ? C_CNT_WIDTH'(1) : '0;
               r_sat[i] <= 1'b0;
            end else if (w_evt[i]) begin
               if (r_cnt[i] == c_cnt_max) begin
                  r_sat[i] <= 1'b1;
               end else begin
                  r_cnt[i] <= r_cnt[i] + C_CNT_WIDTH'(1);
               end
            end
         end
      end
   end

   assign Sl_DBus    = r_dbus;
   assign Sl_xferAck = r_ack;
   assign Sl_errAck  = 1'b0;
   assign Sl_retry   = 1'b0;
   assign Sl_toutSup = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_opb_err_cnt_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_opb_err_cnt_bank
// Brief    : Directed bench for opb_err_cnt_bank (32-bit and 4-bit instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_opb_err_cnt_bank;

   localparam logic [31:0] c_base_a = 32'h01008B00;
   localparam logic [31:0] c_base_b = 32'h01009B00;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [0:31] abus;
   logic [0:3]  be;
   logic [0:31] dbus_w;
   logic        rnw;
   logic        sel;
   logic        seq_addr;
   logic [7:0]  err_a;
   logic [7:0]  err_b;
   logic        cnt_en;

   logic [0:31] dbus_a, dbus_b;
   logic        ack_a, ack_b;
   logic        eack_a, retry_a, tout_a;
   logic        eack_b, retry_b, tout_b;
   logic [31:0] rd;
   logic        ack;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   // Both slaves share the bus; each only responds inside its own window.
   assign rd  = dbus_a | dbus_b;
   assign ack = ack_a | ack_b;

   opb_err_cnt_bank u_dut_a (
      .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be),
      .OPB_DBus(dbus_w), .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq_addr),
      .err_in(err_a), .cnt_en(cnt_en), .Sl_DBus(dbus_a), .Sl_xferAck(ack_a),
      .Sl_errAck(eack_a), .Sl_retry(retry_a), .Sl_toutSup(tout_a)
   );

   opb_err_cnt_bank #(
      .C_BASEADDR(c_base_b), .C_HIGHADDR(32'h01009BFF), .C_CNT_WIDTH(4)
   ) u_dut_b (
      .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be),
      .OPB_DBus(dbus_w), .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq_addr),
      .err_in(err_b), .cnt_en(cnt_en), .Sl_DBus(dbus_b), .Sl_xferAck(ack_b),
      .Sl_errAck(eack_b), .Sl_retry(retry_b), .Sl_toutSup(tout_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One transfer; pa pulses err_a bits during the first hit cycle only.
   task automatic xfer(input logic r, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, input logic [7:0] pa,
                       output logic [31:0] rdata, output int nack, output int bad);
      bit got;
      got = 1'b0; nack = 0; bad = 0; rdata = '0;
      @(negedge clk);
      sel = 1'b1; rnw = r; abus = a; dbus_w = r ? 32'h0 : d; be = b;
      err_a = err_a | pa;
      for (int k = 0; k < 8 && !got; k++) begin
         @(posedge clk); #1;
         if (k == 0) err_a = err_a & ~pa;
         if (ack) begin
            got = 1'b1; nack++; rdata = rd;
         end else if (rd != 32'h0) begin
            bad++;
         end
      end
      // Select held through the cycle after the ack, then released.
      @(posedge clk); #1;
      if (ack) nack++;
      if (rd != 32'h0) bad++;
      @(negedge clk);
      sel = 1'b0; rnw = 1'b1; be = 4'b0000; dbus_w = '0;
      @(posedge clk); #1;
      if (ack) nack++;
      if (rd != 32'h0) bad++;
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] data;
      int nack, bad;
      xfer(1'b1, a, 32'h0, 4'b1111, 8'h00, data, nack, bad);
      check(tag, data, exp);
      check({tag, ":acks"}, nack, 1);
      check({tag, ":idle_dbus"}, bad, 0);
   endtask

   task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b, input logic [7:0] pa);
      logic [31:0] data;
      int nack, bad;
      xfer(1'b0, a, d, b, pa, data, nack, bad);
      check({tag, ":acks"}, nack, 1);
   endtask

   task automatic pulse(input bit on_b, input int ch, input int n);
      @(negedge clk);
      if (on_b) err_b[ch] = 1'b1; else err_a[ch] = 1'b1;
      repeat (n) @(negedge clk);
      if (on_b) err_b[ch] = 1'b0; else err_a[ch] = 1'b0;
   endtask

   initial begin
      bit got;
      rst_n = 1'b0; sel = 1'b0; rnw = 1'b1; abus = '0; dbus_w = '0; be = '0;
      seq_addr = 1'b0; err_a = '0; err_b = '0; cnt_en = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_ack", ack, 1'b0);
      check("rst_dbus", rd, 32'h0);
      @(negedge clk); rst_n = 1'b1;

      rd_chk("id_a", c_base_a + 32'h0C, 32'h00002008);
      rd_chk("shadow3_rst", c_base_a + 32'h1C, 32'h0);
      rd_chk("id_b", c_base_b + 32'h0C, 32'h00000408);

      cnt_en = 1'b1;
      pulse(1'b0, 2, 5);
      wr("snap1", c_base_a, 32'h1, 4'b1111, 8'h00);
      rd_chk("shadow2_5", c_base_a + 32'h18, 32'd5);
      cnt_en = 1'b0;
      pulse(1'b0, 2, 5);
      wr("snap2", c_base_a, 32'h1, 4'b1111, 8'h00);
      rd_chk("shadow2_en0", c_base_a + 32'h18, 32'd5);
      rd_chk("sat_a0", c_base_a + 32'h08, 32'h0);

      cnt_en = 1'b1;
      pulse(1'b1, 0, 20);
      wr("snap_b1", c_base_b, 32'h1, 4'b1111, 8'h00);
      rd_chk("b_shadow0_sat", c_base_b + 32'h10, 32'd15);
      rd_chk("b_sat", c_base_b + 32'h08, 32'h1);
      wr("b_mask", c_base_b + 32'h04, 32'h1, 4'b1111, 8'h00);
      wr("b_clear", c_base_b, 32'h2, 4'b1111, 8'h00);
      wr("snap_b2", c_base_b, 32'h1, 4'b1111, 8'h00);
      rd_chk("b_shadow0_clr", c_base_b + 32'h10, 32'd0);
      rd_chk("b_sat_clr", c_base_b + 32'h08, 32'h0);
      rd_chk("b_mask_rd", c_base_b + 32'h04, 32'h1);

      pulse(1'b0, 1, 3);
      wr("mask_a", c_base_a + 32'h04, 32'h12, 4'b1111, 8'h00);
      wr("clear_evt", c_base_a, 32'h2, 4'b1111, 8'h02);
      wr("snap3", c_base_a, 32'h1, 4'b1111, 8'h00);
      rd_chk("shadow1_clr_evt", c_base_a + 32'h14, 32'd1);

      pulse(1'b0, 4, 7);
      wr("snap_clear", c_base_a, 32'h3, 4'b1111, 8'h00);
      rd_chk("shadow4_pre_clr", c_base_a + 32'h20, 32'd7);
      wr("snap4", c_base_a, 32'h1, 4'b1111, 8'h00);
      rd_chk("shadow4_post_clr", c_base_a + 32'h20, 32'd0);
      rd_chk("shadow1_post_clr", c_base_a + 32'h14, 32'd0);
      rd_chk("shadow2_kept", c_base_a + 32'h18, 32'd5);

      wr("mask_partial_be", c_base_a + 32'h04, 32'hFF, 4'b0011, 8'h00);
      rd_chk("mask_unchanged", c_base_a + 32'h04, 32'h12);
      rd_chk("unmapped_f0", c_base_a + 32'hF0, 32'h0);
      rd_chk("ctrl_rd", c_base_a, 32'h0);
      rd_chk("shadow8_oob", c_base_a + 32'h30, 32'h0);

      // Reset asserted while the ack is high.
      @(negedge clk);
      sel = 1'b1; rnw = 1'b1; abus = c_base_a + 32'h0C; be = 4'b1111;
      got = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
         @(posedge clk); #1;
         if (ack) got = 1'b1;
      end
      check("rst_mid_ack_seen", got, 1'b1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_ack_drop", ack, 1'b0);
      check("rst_mid_dbus", rd, 32'h0);
      @(negedge clk); sel = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      rd_chk("id_after_rst", c_base_a + 32'h0C, 32'h00002008);
      rd_chk("shadow2_after_rst", c_base_a + 32'h18, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/opb_err_cnt_bank.md
Name: opb_err_cnt_bank

Overview:
Parametrised bank of C_N_CH saturating error-event counters with an OPB slave readout, succeeding the single-register simulink-to-PPC counter readout. Software triggers an atomic snapshot of all counters into shadow registers, reads the snapshot, and clears selected channels. The bank sits on the OPB beside the loopback/link blocks. Error strobes arrive already synchronised to OPB_Clk.

Parameters:
C_BASEADDR, 32'h01008B00, first byte address of the slave window
C_HIGHADDR, 32'h01008BFF, last byte address of the slave window
C_OPB_AWIDTH, 32, OPB address width
C_OPB_DWIDTH, 32, OPB data width; only 32 is supported
C_N_CH, 8, number of counter channels; legal range 1..32
C_CNT_WIDTH, 32, counter width; legal range 1..32; zero-extended on reads

Ports:
OPB_Clk  in  1  sole clock
OPB_Rst_n  in  1  reset, asynchronous assert, active-low
OPB_ABus  in  [0:31]  address
OPB_BE  in  [0:3]  byte enables
OPB_DBus  in  [0:31]  write data
OPB_RNW  in  1  1 = read, 0 = write
OPB_select  in  1  transfer in progress
OPB_seqAddr  in  1  ignored
err_in  in  [C_N_CH-1:0]  per-channel error strobe; each high cycle counts one event
cnt_en  in  1  global count enable
Sl_DBus  out  [0:31]  read data
Sl_xferAck  out  1  transfer acknowledge
Sl_errAck, Sl_retry, Sl_toutSup  out  1 each  tied to 0

Behaviour:
- Bit mapping: register bit k is carried on DBus[31-k].
- Reset values: all counters, shadows, CLR_MASK and SAT = 0. Sl_xferAck = 0, Sl_DBus = 0.
- Register map, byte offsets from C_BASEADDR:
  - 0x00 CTRL, write-only. Bit0 = SNAP, bit1 = CLEAR; both self-clearing pulses. Reads return 0.
  - 0x04 CLR_MASK, R/W, C_N_CH bits.
  - 0x08 SAT, read-only. Sticky per-channel saturation flags.
  - 0x0C ID, read-only. Bits[7:0] = C_N_CH, bits[15:8] = C_CNT_WIDTH.
  - 0x10+4*i SHADOW[i], read-only, for i < C_N_CH.
  - Any other in-window address reads 0; writes to it are ignored but acked.
- Address decode: hit = OPB_select and C_BASEADDR <= ABus <= C_HIGHADDR. ABus[30:31] are ignored.
- Handshake:
  - Sl_xferAck is registered and asserts exactly one cycle after the first cycle of a hit.
  - It is held high for one cycle only.
  - The slave does not re-ack while OPB_select stays high in the cycle after an ack.
  - Read data is valid on Sl_DBus only during the ack cycle and is 0 otherwise.
- Writes take effect in the ack cycle and only when OPB_BE = 4'b1111. Writes with partial BE are acked but ignored.
- Counting: each cycle with cnt_en=1 and err_in[i]=1 increments cnt[i] by 1. At all-ones the counter holds and sets SAT[i]; no wrap.
- SNAP: all shadows load the counter values from the same cycle, atomically. An event in that cycle is not in the snapshot but is in the live counter.
- CLEAR: for each i with CLR_MASK[i]=1, cnt[i] and SAT[i] are cleared.
  - An event on a cleared channel in the same cycle makes cnt[i] = 1.
  - Shadows are unaffected by CLEAR.
- SNAP and CLEAR written together: the snapshot takes the pre-clear values, then the clear applies.
- Reading SAT or SHADOW has no side effects.
- Reset asserted mid-transfer: Sl_xferAck drops immediately. After release, the next hit is treated as a new transfer.

Test Plan:
- Reset, then read ID -> 0x00002008 with defaults; read SHADOW[3] -> 0; exactly one ack per read, Sl_DBus = 0 outside the ack cycle.
- Pulse err_in[2] for 5 cycles with cnt_en=1, write CTRL=1, read SHADOW[2] -> 5; repeat with cnt_en=0 -> still 5.
- C_CNT_WIDTH=4: drive err_in[0] for 20 cycles, snapshot -> SHADOW[0]=15, SAT=0x1. Write CLR_MASK=1 then CTRL=2 -> after snapshot SHADOW[0]=0, SAT=0.
- err_in[1] high in the same cycle as CLEAR with mask bit 1 set -> after snapshot SHADOW[1]=1.
- CTRL=3 with cnt[4]=7 and mask bit 4 set -> SHADOW[4]=7; a later snapshot gives 0 (no new events).
- Write with OPB_BE=4'b0011 to CLR_MASK -> acked, CLR_MASK unchanged. Read offset 0xF0 -> 0. Assert OPB_Rst_n low during an ack -> Sl_xferAck = 0 asynchronously.
